// File: rtl/modulo_10_checker_if.sv
// Decade-counter monitor bus: producer-side sample stream in, checker status out.
// Widths of the two counters follow the checker instance they connect to.
interface modulo_10_checker_if #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
);
  logic              in_valid;
  logic [3:0]        in_cnt;
  logic              clr;
  logic              locked;
  logic              err_pulse;
  logic              illegal;
  logic              wrap_pulse;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output in_valid, in_cnt, clr,
    input  locked, err_pulse, illegal, wrap_pulse, err_cnt, wrap_cnt
  );

  modport slave (
    input  in_valid, in_cnt, clr,
    output locked, err_pulse, illegal, wrap_pulse, err_cnt, wrap_cnt
  );
endinterface

// File: rtl/modulo_10_checker.sv
// Self-check monitor for a modulo-MOD counter stream: locks onto 0..MOD-1 stepping,
// flags skips/repeats/illegal codes, counts errors (saturating) and decade wraps.
module modulo_10_checker #(
  parameter int MOD    = 10,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  modulo_10_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] MOD_W = 5'(MOD);
  localparam logic [3:0] LAST  = 4'(MOD - 1);

  state_t            state_reg, state_next;
  logic [3:0]        expected_reg, expected_next;
  logic              err_pulse_reg, err_pulse_next;
  logic              illegal_reg, illegal_next;
  logic              wrap_pulse_reg, wrap_pulse_next;
  logic [ERR_W-1:0]  err_cnt_reg;
  logic [WRAP_W-1:0] wrap_cnt_reg;

  logic       legal;
  logic       match;
  logic [3:0] succ;

  assign legal = ({1'b0, bus.in_cnt} < MOD_W);
  assign match = (bus.in_cnt == expected_reg);
  assign succ  = (bus.in_cnt == LAST) ? 4'd0 : bus.in_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      expected_reg   <= 4'd0;
      err_pulse_reg  <= 1'b0;
      illegal_reg    <= 1'b0;
      wrap_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      expected_reg   <= expected_next;
      err_pulse_reg  <= err_pulse_next;
      illegal_reg    <= illegal_next;
      wrap_pulse_reg <= wrap_pulse_next;
    end
  end

  // Every legal sample re-references the expectation, whatever the state.
  always_comb begin
    state_next      = state_reg;
    expected_next   = expected_reg;
    err_pulse_next  = 1'b0;
    illegal_next    = 1'b0;
    wrap_pulse_next = 1'b0;
    if (bus.in_valid) begin
      illegal_next = ~legal;
      if (legal) begin
        expected_next = succ;
      end
      unique case (state_reg)
        IDLE: begin
          if (legal) begin
            state_next = ACQ;
          end
        end
        ACQ: begin
          if (!legal) begin
            state_next = IDLE;
          end else if (match) begin
            state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (!legal) begin
            state_next     = IDLE;
            err_pulse_next = 1'b1;
          end else if (!match) begin
            state_next     = ACQ;
            err_pulse_next = 1'b1;
          end else begin
            wrap_pulse_next = (bus.in_cnt == 4'd0);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // clr takes priority over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg  <= '0;
      wrap_cnt_reg <= '0;
    end else if (bus.clr) begin
      err_cnt_reg  <= '0;
      wrap_cnt_reg <= '0;
    end else begin
      if (err_pulse_next && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + ERR_W'(1);
      end
      if (wrap_pulse_next) begin
        wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
      end
    end
  end

  assign bus.locked     = (state_reg == LOCKED);
  assign bus.err_pulse  = err_pulse_reg;
  assign bus.illegal    = illegal_reg;
  assign bus.wrap_pulse = wrap_pulse_reg;
  assign bus.err_cnt    = err_cnt_reg;
  assign bus.wrap_cnt   = wrap_cnt_reg;

endmodule

// File: tb/tb_modulo_10_checker.sv
// Randomized and directed bench for modulo_10_checker with a pair-based reference model:
// locked after a sample iff it and the previous valid sample are legal and consecutive.
module tb_modulo_10_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  bit m_locked, m_prev_legal, m_errp, m_ill, m_wrapp;
  int m_prev, m_err, m_err_s, m_wrap;

  modulo_10_checker_if #(.WRAP_W(8), .ERR_W(8)) bus_a ();
  modulo_10_checker_if #(.WRAP_W(8), .ERR_W(2)) bus_b ();

  modulo_10_checker #(.MOD(10), .WRAP_W(8), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  modulo_10_checker #(.MOD(10), .WRAP_W(8), .ERR_W(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    m_locked = 0; m_prev_legal = 0; m_errp = 0; m_ill = 0; m_wrapp = 0;
    m_prev = 0; m_err = 0; m_err_s = 0; m_wrap = 0;
  endtask

  // Drive one cycle of stimulus into both instances and advance the model.
  task automatic step(input bit valid, input int v, input bit c);
    bit legal, now_lock, was;
    @(negedge clk);
    bus_a.in_valid = valid; bus_a.in_cnt = 4'(v); bus_a.clr = c;
    bus_b.in_valid = valid; bus_b.in_cnt = 4'(v); bus_b.clr = c;
    @(posedge clk);
    was = m_locked; m_errp = 0; m_ill = 0; m_wrapp = 0;
    if (valid) begin
      legal    = (v < 10);
      now_lock = legal && m_prev_legal && (v == (m_prev + 1) % 10);
      m_errp   = was && !now_lock;
      m_ill    = !legal;
      m_wrapp  = was && now_lock && (v == 0);
      m_locked = now_lock;
      m_prev_legal = legal;
      if (legal) m_prev = v;
    end
    if (c) begin
      m_err = 0; m_err_s = 0; m_wrap = 0;
    end else begin
      if (m_errp) begin
        m_err   = (m_err < 255) ? m_err + 1 : 255;
        m_err_s = (m_err_s < 3) ? m_err_s + 1 : 3;
      end
      if (m_wrapp) m_wrap = (m_wrap + 1) % 256;
    end
    #1;
    $display("txn t=%0t valid=%0d v=%0d clr=%0d locked=%0d errp=%0d ill=%0d wrapp=%0d err=%0d wrap=%0d",
             $time, valid, v, c, bus_a.locked, bus_a.err_pulse, bus_a.illegal,
             bus_a.wrap_pulse, bus_a.err_cnt, bus_a.wrap_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.in_valid = 0; bus_a.in_cnt = 0; bus_a.clr = 0;
    bus_b.in_valid = 0; bus_b.in_cnt = 0; bus_b.clr = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_a.locked !== 1'b0 || bus_a.err_pulse !== 1'b0 || bus_a.illegal !== 1'b0 ||
        bus_a.wrap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b%b exp=0000", bus_a.locked, bus_a.err_pulse,
               bus_a.illegal, bus_a.wrap_pulse);
    end
    checks++;
    if (bus_a.err_cnt !== 8'd0 || bus_a.wrap_cnt !== 8'd0 || bus_b.err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", bus_a.err_cnt,
               bus_a.wrap_cnt, bus_b.err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic test_count_run();
    for (int i = 0; i < 20; i++) begin
      step(1, i % 10, 0);
      checks++;
      if (bus_a.locked !== (i >= 1)) begin
        failures++;
        $display("FAIL run_locked i=%0d got=%b exp=%b", i, bus_a.locked, (i >= 1));
      end
      checks++;
      if (bus_a.wrap_pulse !== (i == 10) || bus_a.err_pulse !== 1'b0) begin
        failures++;
        $display("FAIL run_pulses i=%0d got wrap=%b err=%b exp wrap=%b err=0", i,
                 bus_a.wrap_pulse, bus_a.err_pulse, (i == 10));
      end
    end
    checks++;
    if (bus_a.wrap_cnt !== 8'd1 || bus_a.err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL run_counters got wrap=%0d err=%0d exp wrap=1 err=0", bus_a.wrap_cnt,
               bus_a.err_cnt);
    end
  endtask

  task automatic test_skip();
    int seq[8] = '{0, 1, 2, 3, 4, 6, 7, 8};
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i], 0);
      checks++;
      if (bus_a.err_pulse !== (seq[i] == 6)) begin
        failures++;
        $display("FAIL skip_err v=%0d got=%b exp=%b", seq[i], bus_a.err_pulse, (seq[i] == 6));
      end
      checks++;
      if (bus_a.locked !== (seq[i] != 6)) begin
        failures++;
        $display("FAIL skip_locked v=%0d got=%b exp=%b", seq[i], bus_a.locked, (seq[i] != 6));
      end
    end
    checks++;
    if (bus_a.err_cnt !== 8'd1 || bus_b.err_cnt !== 2'd1) begin
      failures++;
      $display("FAIL skip_errcnt got=%0d/%0d exp=1/1", bus_a.err_cnt, bus_b.err_cnt);
    end
  endtask

  task automatic test_illegal();
    int seq[7] = '{9, 0, 1, 2, 3, 4, 5};
    foreach (seq[i]) step(1, seq[i], 0);
    step(1, 12, 0);
    checks++;
    if (bus_a.err_pulse !== 1'b1 || bus_a.illegal !== 1'b1 || bus_a.locked !== 1'b0) begin
      failures++;
      $display("FAIL locked_illegal got err=%b ill=%b lock=%b exp err=1 ill=1 lock=0",
               bus_a.err_pulse, bus_a.illegal, bus_a.locked);
    end
    checks++;
    if (bus_a.err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL locked_illegal_cnt got=%0d exp=2", bus_a.err_cnt);
    end
    for (int v = 12; v <= 13; v++) begin
      step(1, v, 0);
      checks++;
      if (bus_a.illegal !== 1'b1 || bus_a.err_pulse !== 1'b0 || bus_a.err_cnt !== 8'd2 ||
          bus_a.locked !== 1'b0) begin
        failures++;
        $display("FAIL idle_illegal v=%0d got ill=%b err=%b cnt=%0d lock=%b exp 1/0/2/0", v,
                 bus_a.illegal, bus_a.err_pulse, bus_a.err_cnt, bus_a.locked);
      end
    end
  endtask

  task automatic test_valid_gap();
    for (int v = 0; v <= 7; v++) step(1, v, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      checks++;
      if (bus_a.locked !== 1'b1 || bus_a.err_pulse !== 1'b0 || bus_a.illegal !== 1'b0 ||
          bus_a.wrap_pulse !== 1'b0) begin
        failures++;
        $display("FAIL gap_flags i=%0d got lock=%b err=%b ill=%b wrap=%b exp 1/0/0/0", i,
                 bus_a.locked, bus_a.err_pulse, bus_a.illegal, bus_a.wrap_pulse);
      end
      checks++;
      if (bus_a.err_cnt !== 8'd2 || bus_a.wrap_cnt !== 8'(m_wrap)) begin
        failures++;
        $display("FAIL gap_counters got err=%0d wrap=%0d exp err=2 wrap=%0d", bus_a.err_cnt,
                 bus_a.wrap_cnt, m_wrap);
      end
    end
    step(1, 8, 0);
    checks++;
    if (bus_a.err_pulse !== 1'b0 || bus_a.locked !== 1'b1) begin
      failures++;
      $display("FAIL gap_resume got err=%b lock=%b exp err=0 lock=1", bus_a.err_pulse,
               bus_a.locked);
    end
  endtask

  task automatic test_saturation();
    int seq[9] = '{9, 9, 0, 0, 1, 1, 2, 2, 3};
    int prev;
    prev = -1;
    foreach (seq[i]) begin
      step(1, seq[i], 0);
      if (seq[i] == prev) begin
        checks++;
        if (bus_a.err_pulse !== 1'b1 || bus_b.err_cnt !== 2'd3) begin
          failures++;
          $display("FAIL stall_sat v=%0d got err=%b cnt_s=%0d exp err=1 cnt_s=3", seq[i],
                   bus_a.err_pulse, bus_b.err_cnt);
        end
      end
      prev = seq[i];
    end
    checks++;
    if (bus_a.err_cnt !== 8'd6 || bus_b.err_cnt !== 2'd3) begin
      failures++;
      $display("FAIL sat_final got=%0d/%0d exp=6/3", bus_a.err_cnt, bus_b.err_cnt);
    end
  endtask

  task automatic test_clr_wrap();
    for (int v = 4; v <= 9; v++) step(1, v, 0);
    step(1, 0, 1);
    checks++;
    if (bus_a.wrap_pulse !== 1'b1 || bus_a.wrap_cnt !== 8'd0 || bus_a.err_cnt !== 8'd0 ||
        bus_b.err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL clr_wrap got wp=%b wrap=%0d err=%0d err_s=%0d exp 1/0/0/0",
               bus_a.wrap_pulse, bus_a.wrap_cnt, bus_a.err_cnt, bus_b.err_cnt);
    end
    step(1, 1, 0);
    checks++;
    if (bus_a.wrap_cnt !== 8'd0 || bus_a.locked !== 1'b1) begin
      failures++;
      $display("FAIL clr_after got wrap=%0d lock=%b exp wrap=0 lock=1", bus_a.wrap_cnt,
               bus_a.locked);
    end
  endtask

  task automatic test_async_reset();
    step(1, 2, 0);
    #2;
    rst = 1'b1;
    bus_a.in_valid = 0; bus_b.in_valid = 0;
    mdl_reset();
    #1;
    checks++;
    if (bus_a.locked !== 1'b0 || bus_a.err_cnt !== 8'd0 || bus_a.wrap_cnt !== 8'd0 ||
        bus_a.err_pulse !== 1'b0 || bus_a.illegal !== 1'b0 || bus_a.wrap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got lock=%b err=%0d wrap=%0d exp all 0", bus_a.locked,
               bus_a.err_cnt, bus_a.wrap_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1, 4, 0);
    checks++;
    if (bus_a.locked !== 1'b0) begin
      failures++;
      $display("FAIL relock_first got=%b exp=0", bus_a.locked);
    end
    step(1, 5, 0);
    checks++;
    if (bus_a.locked !== 1'b1) begin
      failures++;
      $display("FAIL relock_second got=%b exp=1", bus_a.locked);
    end
  endtask

  task automatic test_random();
    int lv, v, sel;
    bit valid, c;
    lv = m_prev;
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 99));
      valid = 1;
      if (sel < 70)      v = (lv + 1) % 10;
      else if (sel < 80) v = int'($urandom_range(0, 9));
      else if (sel < 87) v = lv;
      else if (sel < 93) v = int'($urandom_range(10, 15));
      else begin valid = 0; v = int'($urandom_range(0, 15)); end
      c = ($urandom_range(0, 49) == 0);
      if (valid && v < 10) lv = v;
      step(valid, v, c);
      checks++;
      if (bus_a.locked !== m_locked || bus_a.err_pulse !== m_errp ||
          bus_a.illegal !== m_ill || bus_a.wrap_pulse !== m_wrapp) begin
        failures++;
        $display("FAIL rand_flags n=%0d got=%b%b%b%b exp=%b%b%b%b", n, bus_a.locked,
                 bus_a.err_pulse, bus_a.illegal, bus_a.wrap_pulse, m_locked, m_errp, m_ill,
                 m_wrapp);
      end
      checks++;
      if (bus_a.err_cnt !== 8'(m_err) || bus_a.wrap_cnt !== 8'(m_wrap) ||
          bus_b.err_cnt !== 2'(m_err_s)) begin
        failures++;
        $display("FAIL rand_counters n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n,
                 bus_a.err_cnt, bus_a.wrap_cnt, bus_b.err_cnt, m_err, m_wrap, m_err_s);
      end
    end
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_count_run();
    test_skip();
    test_illegal();
    test_valid_gap();
    test_saturation();
    test_clr_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modulo_10_checker.md
Name: modulo_10_checker

Overview:
- Receiving end of the decade-counter interface: samples a 4-bit count stream from a Modulo_10 style producer and checks that it steps 0,1,...,9,0,... one step per valid sample.
- Locks onto the sequence, flags skips, repeats and illegal codes, and counts errors and decade wraps.
- Sits beside the counter as a self-check monitor in test and debug builds.

Parameters:
MOD, 10, modulus of the expected sequence; legal values are 0..MOD-1 (2..16).
WRAP_W, 8, width of the wrap counter.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  sample in_cnt this cycle.
in_cnt  input  4  count value from the producer.
clr  input  1  synchronous clear of err_cnt and wrap_cnt only.
locked  output  1  high while in the LOCKED state.
err_pulse  output  1  one-cycle pulse per detected error.
illegal  output  1  one-cycle pulse when a sampled value is >= MOD.
wrap_pulse  output  1  one-cycle pulse on a checked MOD-1 to 0 transition.
err_cnt  output  ERR_W  error count, saturating at all-ones.
wrap_cnt  output  WRAP_W  decade wrap count, wrapping modulo 2^WRAP_W.

Behaviour:
- Reset (async assert, sync release): state=IDLE; expected=0; all outputs 0.
- Outputs are registered. Every response appears on the cycle after the rising edge that samples in_valid=1.
- in_valid=0: state, expected and counters hold; pulses drive 0.
- Legal sample v means v < MOD. On every legal sample in every state, nxt(v) = (v==MOD-1) ? 0 : v+1 is loaded into expected.
- FSM states:
  - IDLE: legal sample -> ACQ. Illegal sample -> stay in IDLE; pulse illegal only (no err_pulse).
  - ACQ:
    - v==expected -> LOCKED, locked=1.
    - v!=expected and legal -> stay in ACQ and re-reference on v; no error.
    - Illegal -> IDLE; pulse illegal.
  - LOCKED:
    - v==expected -> stay in LOCKED.
    - v!=expected and legal -> err_pulse, err_cnt+1, ACQ (reference = v), locked=0.
    - Illegal -> err_pulse, illegal, err_cnt+1, IDLE, locked=0.
- wrap_pulse fires only in LOCKED when v==expected and v==0 (that is, the previous checked value was MOD-1). On wrap_pulse, wrap_cnt increments.
- err_cnt saturates at 2^ERR_W-1. wrap_cnt rolls over to 0.
- clr=1 zeroes both counters. If clr coincides with an increment event, clr wins and the counter is 0. Pulses and the FSM are unaffected by clr.
- A repeated value (stall) while in LOCKED counts as an error.
- Errors are counted only in LOCKED. Acquisition mismatches and IDLE illegals are not counted.
- rst mid-stream returns to IDLE immediately. The next lock needs two consecutive correct samples after release.

Test Plan:
- Reset, then feed 0..9,0..9 (in_valid=1 every cycle) -> locked=1 one cycle after the second sample (1). wrap_pulse once, the cycle after the second 0. wrap_cnt=1, err_cnt=0.
- Locked stream 3,4,6,7,8 -> err_pulse one cycle after the 6 is sampled. err_cnt=1, locked=0, then locked=1 again after the 7 (re-acquired on 6).
- Locked stream 5 followed by 12 -> err_pulse and illegal together, state IDLE, locked=0, err_cnt+1. Stream 12,13 from IDLE -> illegal pulses only, err_cnt unchanged.
- Locked stream with in_valid low for 5 cycles between 7 and 8 -> no error, locked stays 1, counters hold.
- Force err_cnt to saturate (ERR_W=2, 4 errors) -> err_cnt=3. Assert clr on the same cycle as a wrap -> wrap_cnt=0.
- Assert rst asynchronously mid-clock while locked -> all outputs 0 without waiting for a clock edge. Sequence 4,5 after release -> locked=1.
